exec_pipe_dpath: RTL

EXEC_PIPE_DPATH -- requirements
Module: exec_pipe_dpath

---
 rtl/exec_pipe_dpath_if.sv | 37 +++
 rtl/exec_pipe_dpath.sv | 86 ++++++++
 2 files changed

// File: rtl/exec_pipe_dpath_if.sv
// Bundle of entry, control, bypass and write-back signals for exec_pipe_dpath.
// The master modport drives the operation and lookups; the slave modport is the datapath.
interface exec_pipe_dpath_if #(
    parameter int WIDTH = 32
);
    logic             in_val;
    logic [1:0]       in_fn;
    logic [WIDTH-1:0] in_op1;
    logic [WIDTH-1:0] in_op2;
    logic [4:0]       in_waddr;
    logic             stall;
    logic             squash;
    logic [4:0]       byp_addr0;
    logic [4:0]       byp_addr1;
    logic             byp_hit0;
    logic             byp_hit1;
    logic [WIDTH-1:0] byp_data0;
    logic [WIDTH-1:0] byp_data1;
    logic             out_val;
    logic [4:0]       out_waddr;
    logic [WIDTH-1:0] out_data;
    logic             eq_X;

    modport master (
        output in_val, in_fn, in_op1, in_op2, in_waddr, stall, squash,
        output byp_addr0, byp_addr1,
        input  byp_hit0, byp_hit1, byp_data0, byp_data1,
        input  out_val, out_waddr, out_data, eq_X
    );

    modport slave (
        input  in_val, in_fn, in_op1, in_op2, in_waddr, stall, squash,
        input  byp_addr0, byp_addr1,
        output byp_hit0, byp_hit1, byp_data0, byp_data1,
        output out_val, out_waddr, out_data, eq_X
    );
endinterface

// File: rtl/exec_pipe_dpath.sv
// Execute-stage result pipeline: ALU result, NSTAGES-deep hold/squash pipe, youngest-first bypass.
// Optional multiplier enabled by defining EXEC_PIPE_DPATH_MUL_EN; otherwise fn=2 yields 0.
module exec_pipe_dpath #(
    parameter int WIDTH   = 32,
    parameter int NSTAGES = 3
) (
    input logic                clk,
    input logic                rst,
    exec_pipe_dpath_if.slave   bus
);
    logic [NSTAGES-1:0]            r_val;
    logic [NSTAGES-1:0][4:0]       r_waddr;
    logic [NSTAGES-1:0][WIDTH-1:0] r_data;

    logic [WIDTH-1:0] w_result;
    logic             w_hit0;
    logic             w_hit1;
    logic [WIDTH-1:0] w_data0;
    logic [WIDTH-1:0] w_data1;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_result = '0;
        case (bus.in_fn)
            2'd0: w_result = bus.in_op1 + bus.in_op2;
            2'd1: w_result = {{(WIDTH-1){1'b0}}, (bus.in_op1 == bus.in_op2)};
`ifdef EXEC_PIPE_DPATH_MUL_EN
            2'd2: w_result = bus.in_op1 * bus.in_op2;
`else
            2'd2: w_result = '0;
`endif
            2'd3: w_result = bus.in_op2;
        endcase
    end

    // NOTE: the data/address registers are reset too, because the write-back and
    // bypass outputs must read as zero straight out of reset, not just be marked invalid.
    // NOTE: sequential state uses non-blocking assignments so every stage samples
    // its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_val   <= '0;
            r_waddr <= '0;
            r_data  <= '0;
        end else if (bus.stall) begin
            // Squash still kills the entry slot while everything else is frozen.
            if (bus.squash) r_val[0] <= 1'b0;
        end else begin
            r_val[0]   <= bus.in_val & ~bus.squash;
            r_waddr[0] <= bus.in_waddr;
            r_data[0]  <= w_result;
            for (int k = 1; k < NSTAGES; k++) begin
                r_val[k]   <= r_val[k-1];
                r_waddr[k] <= r_waddr[k-1];
                r_data[k]  <= r_data[k-1];
            end
        end
    end

    // Scan oldest to youngest so the lowest-index match overwrites older ones.
    always_comb begin
        w_hit0  = 1'b0;
        w_hit1  = 1'b0;
        w_data0 = '0;
        w_data1 = '0;
        for (int k = NSTAGES - 1; k >= 0; k--) begin
            if (r_val[k] && (r_waddr[k] != 5'd0) && (r_waddr[k] == bus.byp_addr0)) begin
                w_hit0  = 1'b1;
                w_data0 = r_data[k];
            end
            if (r_val[k] && (r_waddr[k] != 5'd0) && (r_waddr[k] == bus.byp_addr1)) begin
                w_hit1  = 1'b1;
                w_data1 = r_data[k];
            end
        end
    end

    assign bus.byp_hit0  = w_hit0;
    assign bus.byp_hit1  = w_hit1;
    assign bus.byp_data0 = w_data0;
    assign bus.byp_data1 = w_data1;
    assign bus.out_val   = r_val[NSTAGES-1] & ~bus.stall;
    assign bus.out_waddr = r_waddr[NSTAGES-1];
    assign bus.out_data  = r_data[NSTAGES-1];
    assign bus.eq_X      = r_data[0][0];
endmodule
